// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply
// and restoring divide, one iteration per cycle, holding the pipeline while busy.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [5:0]          cnt;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc;

  logic                is_div_in, a_sgn, b_sgn, a_neg, b_neg, neg_in;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b, special_res;

  logic [XLEN:0]       mul_sum;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   acc_next, prod;
  logic [XLEN-1:0]     quo, rem, final_res;

  // Operand signedness, magnitudes and the divide corner cases, evaluated at acceptance.
  always_comb begin
    is_div_in = op_i[2];
    a_sgn     = is_div_in ? !op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn     = is_div_in ? !op_i[0] : !op_i[1];
    a_neg     = a_sgn & op_a_i[XLEN-1];
    b_neg     = b_sgn & op_b_i[XLEN-1];
    mag_a     = a_neg ? -op_a_i : op_a_i;
    mag_b     = b_neg ? -op_b_i : op_b_i;
    neg_in    = (is_div_in && op_i[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero  = is_div_in && (op_b_i == '0);
    div_ovf   = is_div_in && !op_i[0] && (op_a_i == MIN_NEG) && (op_b_i == '1);
    if (div_zero)
      special_res = op_i[1] ? op_a_i : '1;
    else
      special_res = op_i[1] ? '0 : MIN_NEG;
  end

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_q} : '0);
    div_ge   = acc[2*XLEN-1:XLEN-1] >= {1'b0, opnd_q};
    div_diff = XLEN'(acc[2*XLEN-1:XLEN-1] - {1'b0, opnd_q});
    if (op_q[2])
      acc_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};
    prod = neg_q ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    if (!op_q[2])
      final_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])
      final_res = neg_q ? -rem : rem;
    else
      final_res = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc      <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              op_q  <= op_i;
              neg_q <= neg_in;
              cnt   <= '0;
              if (div_zero || div_ovf) begin
                result_o <= special_res;
                done_o   <= 1'b1;
                state    <= DONE;
              end else begin
                opnd_q <= is_div_in ? mag_b : mag_a;
                acc    <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
                state  <= CALC;
              end
            end
          end
          CALC: begin
            acc <= acc_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'(XLEN-1)) begin
              result_o <= final_res;
              done_o   <= 1'b1;
              state    <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // DONE deliberately drops the stall so the instruction leaves EX with its result.
  assign busy_o  = (state == CALC);
  assign stall_o = ((state == IDLE) && start_i && !flush_i) || (state == CALC);

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed RV32M cases, divide corner cases,
// randomized ops against a reference model, flush, async reset and back-to-back issue.
module tb_mdu_iter;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        stall_o, busy_o, done_o;
  logic [31:0] result_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = '0;

  mdu_iter #(.XLEN(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .op_a_i  (op_a),
    .op_b_i  (op_b),
    .flush_i (flush),
    .stall_o (stall_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .result_o(result_o)
  );

  always #5 clk = ~clk;

  // Reference results straight from 64-bit arithmetic and the RISC-V corner-case rules.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    logic        ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'b0, x};
    uy  = {32'b0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: if (y == 0) return 32'hFFFF_FFFF; else if (ovf) return 32'h8000_0000; else return $signed(x) / $signed(y);
      3'd5: if (y == 0) return 32'hFFFF_FFFF; else return x / y;
      3'd6: if (y == 0) return x; else if (ovf) return 32'h0; else return $signed(x) % $signed(y);
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  // Drives one instruction at a negedge, pushes its expected result, and waits for done_o.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] exp, output logic seen, output logic [31:0] got,
                                output int lat, output int stalls);
    start = 1'b1;
    op    = o;
    op_a  = x;
    op_b  = y;
    exp_q.push_back(exp);
    seen   = 1'b0;
    got    = '0;
    lat    = 0;
    stalls = 0;
    #1;
    if (stall_o) stalls++;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (done_o) begin
        seen = 1'b1;
        got  = result_o;
      end else if (stall_o) begin
        stalls++;
      end
    end
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    checks++; if (result_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got=%h want=%h", result_o, 32'h0); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b want=0", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b want=0", stall_o); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_prio_stall got=%b want=0", stall_o); end
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_prio_busy got=%b want=0", busy_o); end
    start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    vec_t        v[4];
    logic        seen;
    logic [31:0] got, want;
    int          lat, stalls;
    v = '{'{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
          '{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
          '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
          '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(v[i].op, v[i].a, v[i].b, v[i].exp, seen, got, lat, stalls);
      want = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL mul_timeout op=%0d got=no_done want=done", v[i].op); end
      else begin
        last_result = want;
        checks++; if (got !== want) begin errors++; $display("[TB] FAIL mul_result op=%0d got=%h want=%h", v[i].op, got, want); end
        checks++; if (lat != 33) begin errors++; $display("[TB] FAIL mul_latency op=%0d got=%0d want=33", v[i].op, lat); end
        checks++; if (stalls != 33) begin errors++; $display("[TB] FAIL mul_stall op=%0d got=%0d want=33", v[i].op, stalls); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy_in_done got=%b want=0", busy_o); end
      end
      idle_cycle();
    end
  endtask

  task automatic test_div();
    vec_t        v[4];
    logic        seen;
    logic [31:0] got, want;
    int          lat, stalls;
    v = '{'{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD},
          '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
          '{3'd5, 32'd100, 32'd7, 32'd14},
          '{3'd7, 32'd100, 32'd7, 32'd2}};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(v[i].op, v[i].a, v[i].b, v[i].exp, seen, got, lat, stalls);
      want = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL div_timeout op=%0d got=no_done want=done", v[i].op); end
      else begin
        last_result = want;
        checks++; if (got !== want) begin errors++; $display("[TB] FAIL div_result op=%0d got=%h want=%h", v[i].op, got, want); end
        checks++; if (lat != 33) begin errors++; $display("[TB] FAIL div_latency op=%0d got=%0d want=33", v[i].op, lat); end
        checks++; if (stalls != 33) begin errors++; $display("[TB] FAIL div_stall op=%0d got=%0d want=33", v[i].op, stalls); end
      end
      idle_cycle();
    end
  endtask

  task automatic test_special();
    vec_t        v[4];
    logic        seen;
    logic [31:0] got, want;
    int          lat, stalls;
    v = '{'{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF},
          '{3'd6, 32'd5, 32'd0, 32'd5},
          '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
          '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0}};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(v[i].op, v[i].a, v[i].b, v[i].exp, seen, got, lat, stalls);
      want = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL special_timeout op=%0d got=no_done want=done", v[i].op); end
      else begin
        last_result = want;
        checks++; if (got !== want) begin errors++; $display("[TB] FAIL special_result op=%0d got=%h want=%h", v[i].op, got, want); end
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL special_latency op=%0d got=%0d want=1", v[i].op, lat); end
        checks++; if (stalls != 1) begin errors++; $display("[TB] FAIL special_stall op=%0d got=%0d want=1", v[i].op, stalls); end
      end
      idle_cycle();
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, got, want;
    logic        seen, special;
    int          lat, stalls, want_lat;
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      special  = o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
      want_lat = special ? 1 : 33;
      apply_stimulus(o, x, y, ref_result(o, x, y), seen, got, lat, stalls);
      want = exp_q.pop_front();
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL rand_timeout op=%0d got=no_done want=done", o); end
      else begin
        last_result = want;
        checks++; if (got !== want) begin errors++; $display("[TB] FAIL rand_result op=%0d a=%h b=%h got=%h want=%h", o, x, y, got, want); end
        checks++; if (lat != want_lat) begin errors++; $display("[TB] FAIL rand_latency op=%0d got=%0d want=%0d", o, lat, want_lat); end
      end
      idle_cycle();
    end
  endtask

  task automatic test_flush();
    logic        seen, stray;
    logic [31:0] got, want;
    int          lat, stalls;
    start = 1'b1;
    op    = 3'd4;
    op_a  = 32'hFFFF_FFF9;
    op_b  = 32'd2;
    repeat (11) @(negedge clk);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy_before got=%b want=1", busy_o); end
    flush = 1'b1;
    start = 1'b0;
    #1;
    checks++; if (stall_o !== 1'b1) begin errors++; $display("[TB] FAIL flush_stall_same_cycle got=%b want=1", stall_o); end
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_busy_after got=%b want=0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall_after got=%b want=0", stall_o); end
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_done got=%b want=0", stray); end
    checks++; if (result_o !== last_result) begin errors++; $display("[TB] FAIL flush_result_held got=%h want=%h", result_o, last_result); end
    apply_stimulus(3'd0, 32'd3, 32'd4, 32'd12, seen, got, lat, stalls);
    want = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL post_flush_timeout got=no_done want=done"); end
    else begin
      last_result = want;
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL post_flush_result got=%h want=%h", got, want); end
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL post_flush_latency got=%0d want=33", lat); end
    end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    logic stray;
    start = 1'b1;
    op    = 3'd0;
    op_a  = 32'd9;
    op_b  = 32'd9;
    repeat (6) @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (result_o !== 32'h0) begin errors++; $display("[TB] FAIL areset_result got=%h want=%h", result_o, 32'h0); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got=%b want=0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_stall got=%b want=0", stall_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_done got=%b want=0", done_o); end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL areset_no_done got=%b want=0", stray); end
  endtask

  task automatic test_back_to_back();
    logic        seen;
    logic [31:0] got, want;
    int          lat, stalls;
    apply_stimulus(3'd0, 32'd2, 32'd3, 32'd6, seen, got, lat, stalls);
    want = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL b2b_first_timeout got=no_done want=done"); end
    else begin
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL b2b_first_result got=%h want=%h", got, want); end
      checks++; if (lat != 33) begin errors++; $display("[TB] FAIL b2b_first_latency got=%0d want=33", lat); end
    end
    // Issued during the DONE cycle: one edge to reach IDLE, then accepted without a gap.
    apply_stimulus(3'd0, 32'd4, 32'd5, 32'd20, seen, got, lat, stalls);
    want = exp_q.pop_front();
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL b2b_second_timeout got=no_done want=done"); end
    else begin
      checks++; if (got !== want) begin errors++; $display("[TB] FAIL b2b_second_result got=%h want=%h", got, want); end
      checks++; if (lat != 34) begin errors++; $display("[TB] FAIL b2b_second_latency got=%0d want=34", lat); end
      checks++; if (stalls != 33) begin errors++; $display("[TB] FAIL b2b_second_stall got=%0d want=33", stalls); end
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
